// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register write-port arbiter.
// The statistics counters only exist when REG_ARB_STATS_EN is defined.
package reg_arb_pkg;

   // Arbiter FSM: free-running round robin, or one requester owns the register.
   typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

   // Width of the saturating statistics counters.
   localparam int STAT_W = 32;

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Round-robin pick: first set bit of req scanning from ptr upward, modulo NREQ.
// Built as a double-width masked priority scan: the low copy of req has the
// bits below ptr cleared, so the lowest set bit of {req, masked_req} is the
// round-robin winner, and its position modulo NREQ is the requester index.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic            any,
   output logic [IDW-1:0]  win_idx,
   output logic [NREQ-1:0] win_onehot
);

   logic [2*NREQ-1:0] dbl;

   // Mask, scan from the top down so the lowest set bit is the last assignment.
   always_comb begin
      dbl = {req, req};
      for (int i = 0; i < NREQ; i++) begin
         if (i < int'(ptr)) dbl[i] = 1'b0;
      end
      any     = |req;
      win_idx = '0;
      for (int i = 2*NREQ-1; i >= 0; i--) begin
         if (dbl[i]) win_idx = i[IDW-1:0];
      end
      win_onehot = '0;
      if (any) win_onehot[win_idx] = 1'b1;
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one write-enabled register among NREQ requesters.
// gnt is a registered one-hot write acknowledge (write latency 1). A winner
// that also raises lock takes ownership until it drops lock.
// owner_valid is the FSM state made visible (high exactly in ARB_LOCKED).
// Optional: define REG_ARB_STATS_EN to add write_count and lock_cycles.
//
// Handshake: a requester holds req and wdata stable until it sees its gnt bit;
// each cycle a gnt bit is high acknowledges exactly one write.
module reg_write_arbiter
   import reg_arb_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int NREQ  = 4,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ-1:0]       lock,
   input  logic [NREQ*WIDTH-1:0] wdata,
   output logic [NREQ-1:0]       gnt,
   output logic [WIDTH-1:0]      data_out,
   output logic                  owner_valid,
   output logic [IDW-1:0]        owner_id
`ifdef REG_ARB_STATS_EN
   ,
   output logic [STAT_W-1:0]     write_count,
   output logic [STAT_W-1:0]     lock_cycles
`endif
);

   if (WIDTH < 1) begin : g_bad_width
      $error("reg_write_arbiter: WIDTH must be > 0");
   end
   if ((NREQ < 2) || ((NREQ & (NREQ - 1)) != 0)) begin : g_bad_nreq
      $error("reg_write_arbiter: NREQ must be a power of 2 and >= 2");
   end

   arb_state_t       state;
   logic [IDW-1:0]   ptr;
   logic             pick_any;
   logic [IDW-1:0]   pick_idx;
   logic [NREQ-1:0]  pick_onehot;
   logic             we;
   logic [IDW-1:0]   widx;
   logic [NREQ-1:0]  gnt_next;
   logic [WIDTH-1:0] wsel;

   rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
      .req        (req),
      .ptr        (ptr),
      .any        (pick_any),
      .win_idx    (pick_idx),
      .win_onehot (pick_onehot)
   );

   // Decide who writes this edge: the round-robin winner, or only the owner when locked.
   always_comb begin
      we       = 1'b0;
      widx     = pick_idx;
      gnt_next = '0;
      if (state == ARB_IDLE) begin
         we       = pick_any;
         widx     = pick_idx;
         gnt_next = pick_onehot;
      end else begin
         we   = req[owner_id];
         widx = owner_id;
         if (we) gnt_next[owner_id] = 1'b1;
      end
      wsel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (i == int'(widx)) wsel = wdata[i*WIDTH +: WIDTH];
      end
   end

   // Data register and registered acknowledge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out <= '0;
         gnt      <= '0;
      end else begin
         if (we) data_out <= wsel;
         gnt <= gnt_next;
      end
   end

   // Lock FSM and round-robin pointer; the pointer only moves when a grant is not locking.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ARB_IDLE;
         ptr      <= '0;
         owner_id <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (pick_any) begin
                  if (lock[pick_idx]) begin
                     state    <= ARB_LOCKED;
                     owner_id <= pick_idx;
                  end else begin
                     ptr <= pick_idx + IDW'(1);
                  end
               end
            end
            default: begin
               if (!lock[owner_id]) begin
                  state <= ARB_IDLE;
                  ptr   <= owner_id + IDW'(1);
               end
            end
         endcase
      end
   end

   assign owner_valid = (state == ARB_LOCKED);

`ifdef REG_ARB_STATS_EN
   // Saturating counters of completed writes and of cycles spent locked.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         write_count <= '0;
         lock_cycles <= '0;
      end else begin
         if (we && (write_count != '1)) write_count <= write_count + STAT_W'(1);
         if ((state == ARB_LOCKED) && (lock_cycles != '1)) lock_cycles <= lock_cycles + STAT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed vector table, hand-written
// lock and mid-lock reset sequences, then random traffic against a reference model.
module tb_reg_write_arbiter;

  localparam int WIDTH = 64;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       lock;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      data_out;
  logic                  owner_valid;
  logic [IDW-1:0]        owner_id;
  logic [WIDTH-1:0]      wd [NREQ];
`ifdef REG_ARB_STATS_EN
  logic [31:0]           write_count;
  logic [31:0]           lock_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit               m_locked;
  int               m_owner;
  int               m_ptr;
  logic [WIDTH-1:0] m_data;
  logic [NREQ-1:0]  m_gnt;
  longint unsigned  m_writes;
  longint unsigned  m_lock_cyc;

  reg_write_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .lock        (lock),
    .wdata       (wdata),
    .gnt         (gnt),
    .data_out    (data_out),
    .owner_valid (owner_valid),
    .owner_id    (owner_id)
`ifdef REG_ARB_STATS_EN
    ,
    .write_count (write_count),
    .lock_cycles (lock_cycles)
`endif
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) wdata[i*WIDTH +: WIDTH] = wd[i];
  end

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked   = 0;
    m_owner    = 0;
    m_ptr      = 0;
    m_data     = '0;
    m_gnt      = '0;
    m_writes   = 0;
    m_lock_cyc = 0;
  endtask

  // One clock edge of the arbiter rules, applied to the current inputs.
  task automatic model_edge(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l);
    int w;
    m_gnt = '0;
    if (m_locked) begin
      m_lock_cyc++;
      if (r[m_owner]) begin
        m_data = wd[m_owner];
        m_gnt  = NREQ'(1) << m_owner;
      end
      if (!l[m_owner]) begin
        m_locked = 0;
        m_ptr    = (m_owner + 1) % NREQ;
      end
    end else if (r != '0) begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (w < 0 && r[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      end
      m_data = wd[w];
      m_gnt  = NREQ'(1) << w;
      if (l[w]) begin
        m_locked = 1;
        m_owner  = w;
      end else begin
        m_ptr = (w + 1) % NREQ;
      end
    end
    if (m_gnt != '0) m_writes++;
  endtask

  task automatic check_all();
    check("gnt", WIDTH'(gnt), WIDTH'(m_gnt));
    check("data_out", data_out, m_data);
    check("owner_valid", WIDTH'(owner_valid), WIDTH'(m_locked));
    if (m_locked) check("owner_id", WIDTH'(owner_id), WIDTH'(m_owner));
`ifdef REG_ARB_STATS_EN
    check("write_count", WIDTH'(write_count), WIDTH'(m_writes));
    check("lock_cycles", WIDTH'(lock_cycles), WIDTH'(m_lock_cyc));
`endif
  endtask

  // driver: called at a negedge, applies inputs, samples 1ns after the next posedge
  task automatic step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l);
    req  = r;
    lock = l;
    model_edge(r, l);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  typedef struct {
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  lock;
    logic [NREQ-1:0]  exp_gnt;
    logic [WIDTH-1:0] exp_data;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // round robin from ptr=0, then a ptr=3 wrap case, then idle
    vecs[0] = '{4'b0000, 4'b0000, 4'b0000, 64'h0};
    vecs[1] = '{4'b1111, 4'b0000, 4'b0001, 64'hA0};
    vecs[2] = '{4'b1111, 4'b0000, 4'b0010, 64'hA1};
    vecs[3] = '{4'b1111, 4'b0000, 4'b0100, 64'hA2};
    vecs[4] = '{4'b1111, 4'b0000, 4'b1000, 64'hA3};
    vecs[5] = '{4'b1111, 4'b0000, 4'b0001, 64'hA0};
    vecs[6] = '{4'b0100, 4'b0000, 4'b0100, 64'hA2};
    vecs[7] = '{4'b1001, 4'b0000, 4'b1000, 64'hA3};
    vecs[8] = '{4'b1001, 4'b0000, 4'b0001, 64'hA0};
    vecs[9] = '{4'b0000, 4'b1111, 4'b0000, 64'hA0};

    reset = 1'b1;
    req   = '0;
    lock  = '0;
    for (int i = 0; i < NREQ; i++) wd[i] = 64'hA0 + 64'(i);
    model_reset();
    #12;
    check("reset_gnt", WIDTH'(gnt), '0);
    check("reset_data", data_out, '0);
    check("reset_owner_valid", WIDTH'(owner_valid), '0);
    check("reset_owner_id", WIDTH'(owner_id), '0);
    @(negedge clk);
    reset = 1'b0;

    // idle cycles
    for (int i = 0; i < 3; i++) step('0, '0);

    // directed vector table
    for (int v = 0; v < 10; v++) begin
      step(vecs[v].req, vecs[v].lock);
      check($sformatf("vec%0d_gnt", v), WIDTH'(gnt), WIDTH'(vecs[v].exp_gnt));
      check($sformatf("vec%0d_data", v), data_out, vecs[v].exp_data);
    end

    // lock sequence: ptr=1, requester 1 locks for 4 writes while everyone requests
    for (int c = 0; c < 4; c++) begin
      wd[1] = 64'h10 + 64'(c);
      step(4'b1111, 4'b0010);
      check("lock_gnt", WIDTH'(gnt), WIDTH'(4'b0010));
      check("lock_data", data_out, 64'h10 + 64'(c));
      check("lock_owner", WIDTH'(owner_id), 64'd1);
      check("lock_valid", WIDTH'(owner_valid), 64'd1);
    end
    step(4'b1101, 4'b0000);
    check("unlock_gnt", WIDTH'(gnt), '0);
    check("unlock_valid", WIDTH'(owner_valid), '0);
    step(4'b1101, 4'b0000);
    check("post_lock_gnt", WIDTH'(gnt), WIDTH'(4'b0100));

    // reset in the middle of a lock, off the clock edge
    step(4'b1000, 4'b1000);
    check("relock_valid", WIDTH'(owner_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("midreset_gnt", WIDTH'(gnt), '0);
    check("midreset_data", data_out, '0);
    check("midreset_valid", WIDTH'(owner_valid), '0);
    check("midreset_owner", WIDTH'(owner_id), '0);
    @(negedge clk);
    reset = 1'b0;
    step(4'b0100, 4'b0000);
    check("after_reset_gnt", WIDTH'(gnt), WIDTH'(4'b0100));

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) wd[i] = {$urandom, $urandom};
      step(NREQ'($urandom_range(0, 15)), NREQ'($urandom & $urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
